id_queue: RTL and testbench
===========================

ID_QUEUE -- requirements
Module: id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter PC_W, default 32, meaning PC/branch-address width.
REQ-003 SHALL have ports: clk input 1 (single clock, rising edge); resetn input 1 (asynchronous, active-low reset).
REQ-004 SHALL have ports: in_valid input 1, in_ready output 1, in_pc input PC_W, in_inst input 32: IF-to-queue handshake.
REQ-005 SHALL have ports: out_valid output 1, out_ready input 1, out_pc output PC_W, out_inst output 32, out_rdata1/out_rdata2 output 32, out_rf_we output 1, out_rf_waddr output 5: issue to EX.
REQ-006 SHALL have ports: rf_raddr1/rf_raddr2 output 5, rf_rdata1/rf_rdata2 input 32: combinational regfile read.
REQ-007 SHALL have ports: ex_wreg input 1, ex_is_load input 1, ex_waddr input 5, ex_wdata input 32, mem_wreg input 1, mem_waddr input 5, mem_wdata input 32: forwarding sources.
REQ-008 SHALL have ports: flush input 1; br_e output 1; br_addr output PC_W; stallreq output 1.

Function
REQ-009 SHALL hold up to DEPTH {pc,inst} entries in FIFO order with PC_W-independent log2(DEPTH)-bit wrapping pointers and a 0..DEPTH count.
REQ-010 SHALL push on in_valid&in_ready; in_ready = (count<DEPTH) & ~flush & ~br_e; no push at full even if a pop occurs that cycle.
REQ-011 SHALL decode the head: addu, subu, ori, lui, addiu, beq, bne, j, jal, jr; other encodings issue as nop (rf_we=0).
REQ-012 SHALL set out_rf_waddr: rd for addu/subu, rt for ori/lui/addiu, 31 for jal, 0 otherwise; out_rf_we=1 only for these.
REQ-013 SHALL drive rf_raddr1=inst[25:21], rf_raddr2=inst[20:16] of the head.
REQ-014 SHALL resolve operands per source: address 0 -> 0; else EX match (ex_wreg) -> ex_wdata; else MEM match -> mem_wdata; else rf_rdata.
REQ-015 SHALL detect load-use when ex_wreg&ex_is_load&ex_waddr!=0 matches a source the head actually reads; then out_valid=0, stallreq=1, head held.
REQ-016 SHALL assert out_valid when queue non-empty, no load-use hazard, ~flush, state not WAIT_DS-empty; pop on out_valid&out_ready.
REQ-017 SHALL pulse br_e=1 only in the issue cycle of: beq with equal operands, bne unequal, j, jal, jr.
REQ-018 SHALL compute br_addr: beq/bne pc+4+(sext(imm)<<2); j/jal {pc+4[PC_W-1:28],index,2'b00}; jr operand1; 0 when br_e=0.
REQ-019 SHALL, on br_e, keep only the entry directly behind the branch (delay slot) and discard the rest.
REQ-020 SHALL run FSM RUN/WAIT_DS: taken branch with no entry behind -> WAIT_DS; in WAIT_DS next accepted entry is kept -> RUN; otherwise stays RUN.
REQ-021 SHALL, on flush, empty the queue and enter RUN in the next cycle; flush overrides push, pop and br_e (br_e=0 during flush).
REQ-022 SHALL hold all outputs stable while out_valid&~out_ready.
REQ-023 SHALL have minimum input-to-issue latency 1 cycle (entry registered before issue) unless ID_BYPASS_EN.

Reset
REQ-024 SHALL on resetn=0 asynchronously clear pointers, count, FSM to RUN; out_valid=0, in_ready=0 during reset, br_e=0, br_addr=0, stallreq=0, out_* data=0.
REQ-025 SHALL discard all entries if reset asserts mid-operation; in_ready rises first rising edge after resetn=1.

Configuration
REQ-026 SHALL support macro ID_BYPASS_EN: defined -> push into empty RUN-state queue with out_ready=1 and no hazard issues same cycle (0 latency, not stored); undefined -> REQ-023 latency, no bypass logic.

Verification
REQ-027 Push 4 addiu with out_ready=0, DEPTH=4 -> in_ready=0 after 4th; out_ready=1 -> issue in order, pcs 0x0,0x4,0x8,0xC.
REQ-028 Head addu $3,$1,$2; ex_wreg, ex_waddr=1, ex_wdata=0x11; mem_waddr=2, mem_wdata=0x22 -> out_rdata1=0x11, out_rdata2=0x22.
REQ-029 Head reads $5, ex_is_load, ex_waddr=5 -> out_valid=0, stallreq=1; drop ex_is_load -> issue next cycle.
REQ-030 beq equal at pc 0x100, imm=4, three entries behind -> br_e=1, br_addr=0x114, only 0x104 remains.
REQ-031 jal at pc 0x200 alone in queue -> WAIT_DS, next pushed entry kept, out_rf_waddr=31; flush mid-WAIT_DS -> empty, RUN.
REQ-032 resetn low with 3 entries -> out_valid=0 immediately, count=0 after release; with ID_BYPASS_EN, push to empty issues same cycle.

Source files
------------

// File: rtl/id_queue.sv
// id_queue -- instruction queue between IF and EX with decode, operand
// forwarding, load-use stall and branch resolution for a small MIPS subset
// (addu, subu, ori, lui, addiu, beq, bne, j, jal, jr; all else issues as nop).
//
// Parameters: DEPTH entries (power of two, 2..16), PC_W address width (>28).
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   in_valid/in_ready/in_pc/in_inst           push side from IF
//   out_valid/out_ready/out_pc/out_inst/out_rdata1/out_rdata2/
//   out_rf_we/out_rf_waddr                    issue side to EX
//   rf_raddr1/rf_raddr2, rf_rdata1/rf_rdata2  combinational regfile read
//   ex_*/mem_*                                forwarding sources
//   flush, br_e, br_addr, stallreq            pipeline control
// Optional feature macro: ID_BYPASS_EN -- a push into an empty queue in RUN
// state with out_ready=1 and no hazard issues in the same cycle without being
// stored. When undefined, every entry is registered before it issues.
module id_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [31:0]     out_rdata1,
  output logic [31:0]     out_rdata2,
  output logic            out_rf_we,
  output logic [4:0]      out_rf_waddr,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [31:0]     rf_rdata1,
  input  logic [31:0]     rf_rdata2,
  input  logic            ex_wreg,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_waddr,
  input  logic [31:0]     ex_wdata,
  input  logic            mem_wreg,
  input  logic [4:0]      mem_waddr,
  input  logic [31:0]     mem_wdata,
  input  logic            flush,
  output logic            br_e,
  output logic [PC_W-1:0] br_addr,
  output logic            stallreq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {ST_RUN, ST_WAIT_DS} state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             rst_done_reg;   // holds in_ready low until the first edge after reset

  logic [PC_W-1:0]  pc_mem  [DEPTH];
  logic [31:0]      inst_mem[DEPTH];

  logic             has_entry, in_ready_base, head_present, bypass_go;
  logic [PC_W-1:0]  head_pc;
  logic [31:0]      head_inst;

  assign has_entry     = (count_reg != '0);
  assign in_ready_base = rst_done_reg & (count_reg < CNT_W'(DEPTH)) & ~flush;

  // Head selection: the stored head, or the incoming entry when bypassing.
  // An absent head reads as all-zero, which decodes as a nop and zeroes outputs.
`ifdef ID_BYPASS_EN
  logic bypass_cand;
  assign bypass_cand  = ~has_entry & (state_reg == ST_RUN) & in_valid & in_ready_base & out_ready;
  assign head_present = has_entry | bypass_cand;
  assign head_pc      = has_entry ? pc_mem[rd_ptr_reg]   : (bypass_cand ? in_pc   : '0);
  assign head_inst    = has_entry ? inst_mem[rd_ptr_reg] : (bypass_cand ? in_inst : '0);
`else
  assign head_present = has_entry;
  assign head_pc      = has_entry ? pc_mem[rd_ptr_reg]   : '0;
  assign head_inst    = has_entry ? inst_mem[rd_ptr_reg] : '0;
`endif

  // Decode
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_addiu, is_beq, is_bne, is_j, is_jal;
  logic reads1, reads2, hazard;

  assign op       = head_inst[31:26];
  assign funct    = head_inst[5:0];
  assign rs       = head_inst[25:21];
  assign rt       = head_inst[20:16];
  assign rd       = head_inst[15:11];
  assign is_r     = (op == 6'h00);
  assign is_addu  = is_r & (funct == 6'h21);
  assign is_subu  = is_r & (funct == 6'h23);
  assign is_jr    = is_r & (funct == 6'h08);
  assign is_ori   = (op == 6'h0D);
  assign is_lui   = (op == 6'h0F);
  assign is_addiu = (op == 6'h09);
  assign is_beq   = (op == 6'h04);
  assign is_bne   = (op == 6'h05);
  assign is_j     = (op == 6'h02);
  assign is_jal   = (op == 6'h03);

  // Only sources the instruction really consumes can create a load-use stall.
  assign reads1 = is_addu | is_subu | is_jr | is_ori | is_addiu | is_beq | is_bne;
  assign reads2 = is_addu | is_subu | is_beq | is_bne;

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // Operand resolution: $0, then EX, then MEM, then register file.
  assign out_rdata1 = (rs == 5'd0)                    ? 32'd0     :
                      (ex_wreg  && ex_waddr  == rs)   ? ex_wdata  :
                      (mem_wreg && mem_waddr == rs)   ? mem_wdata : rf_rdata1;
  assign out_rdata2 = (rt == 5'd0)                    ? 32'd0     :
                      (ex_wreg  && ex_waddr  == rt)   ? ex_wdata  :
                      (mem_wreg && mem_waddr == rt)   ? mem_wdata : rf_rdata2;

  assign hazard = ex_wreg & ex_is_load & (ex_waddr != 5'd0) &
                  ((reads1 & (ex_waddr == rs)) | (reads2 & (ex_waddr == rt)));

  assign out_pc       = head_pc;
  assign out_inst     = head_inst;
  assign out_rf_we    = is_addu | is_subu | is_ori | is_lui | is_addiu | is_jal;
  assign out_rf_waddr = (is_addu | is_subu)          ? rd    :
                        (is_ori | is_lui | is_addiu) ? rt    :
                        is_jal                       ? 5'd31 : 5'd0;

  assign out_valid = head_present & ~hazard & ~flush;
  assign stallreq  = has_entry & hazard;

  // Branch resolution
  logic            issue, taken;
  logic [PC_W-1:0] pc_plus4, imm_sext, target;

  assign issue    = out_valid & out_ready;
  assign pc_plus4 = head_pc + PC_W'(4);
  assign imm_sext = {{(PC_W-16){head_inst[15]}}, head_inst[15:0]};
  assign taken    = (is_beq & (out_rdata1 == out_rdata2)) | (is_bne & (out_rdata1 != out_rdata2)) |
                    is_j | is_jal | is_jr;
  assign target   = (is_beq | is_bne) ? pc_plus4 + (imm_sext << 2) :
                    is_jr             ? PC_W'(out_rdata1)           :
                                        {pc_plus4[PC_W-1:28], head_inst[25:0], 2'b00};
  assign br_e     = issue & taken;
  assign br_addr  = br_e ? target : '0;

`ifdef ID_BYPASS_EN
  assign bypass_go = bypass_cand & ~hazard;
`else
  assign bypass_go = 1'b0;
`endif

  // A bypassed branch has already consumed the input, so its br_e must not
  // retract the in_ready that accepted it.
  assign in_ready = in_ready_base & ~(br_e & ~bypass_go);

  logic push, pop;
  assign push = in_valid & in_ready & ~bypass_go;
  assign pop  = issue & ~bypass_go;

  always_comb begin
    state_next  = state_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      state_next  = ST_RUN;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else if (br_e) begin
      if (bypass_go) begin
        state_next = ST_WAIT_DS;
      end else if (count_reg >= CNT_W'(2)) begin
        // Keep only the delay slot directly behind the branch.
        state_next  = ST_RUN;
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        wr_ptr_next = rd_ptr_reg + PTR_W'(2);
        count_next  = CNT_W'(1);
      end else begin
        // Delay slot not fetched yet: the next accepted entry is it.
        state_next  = ST_WAIT_DS;
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        wr_ptr_next = rd_ptr_reg + PTR_W'(1);
        count_next  = '0;
      end
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_next = count_reg + CNT_W'(1);
      else if (pop && !push) count_next = count_reg - CNT_W'(1);
      if (push && state_reg == ST_WAIT_DS) state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_RUN;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      rst_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      rst_done_reg <= 1'b1;
    end
  end

  // Entry storage carries no reset; validity comes from count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= in_pc;
      inst_mem[wr_ptr_reg] <= in_inst;
    end
  end
endmodule

// File: tb/tb_id_queue.sv
// Directed testbench for id_queue (default build, DEPTH=4, PC_W=32).
module tb_id_queue;
  logic        clk, resetn;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst, out_rdata1, out_rdata2;
  logic        out_rf_we;
  logic [4:0]  out_rf_waddr, rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_wreg, ex_is_load, mem_wreg;
  logic [4:0]  ex_waddr, mem_waddr;
  logic [31:0] ex_wdata, mem_wdata;
  logic        flush, br_e, stallreq;
  logic [31:0] br_addr;

  int n_vec = 0;
  int n_bad = 0;

  id_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .flush(flush), .br_e(br_e), .br_addr(br_addr), .stallreq(stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_addu(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, 6'h21};
  endfunction

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
    rf_rdata1 = '0; rf_rdata2 = '0; ex_wreg = 1'b0; ex_is_load = 1'b0; ex_waddr = '0;
    ex_wdata = '0; mem_wreg = 1'b0; mem_waddr = '0; mem_wdata = '0; flush = 1'b0;

    // Reset state
    #2;
    check("rst.in_ready",  32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.br_e",      32'(br_e), 32'd0);
    check("rst.br_addr",   br_addr, 32'd0);
    check("rst.stallreq",  32'(stallreq), 32'd0);
    check("rst.out_pc",    out_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #2 check("rel.in_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    #2 check("rel.in_ready_after_edge", 32'(in_ready), 32'd1);

    // Fill to DEPTH with out_ready low, then drain in order
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'(i * 4);
      in_inst  = enc_i(6'h09, 5'd0, 5'(i + 1), 16'(i));
      #2;
      check("fill.in_ready", 32'(in_ready), 32'd1);
      if (i == 0) check("fill.latency", 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    #2;
    check("full.in_ready",  32'(in_ready), 32'd0);
    check("full.out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("drain.pc",    out_pc, 32'(i * 4));
      check("drain.waddr", 32'(out_rf_waddr), 32'(i + 1));
      check("drain.we",    32'(out_rf_we), 32'd1);
      tick();
    end
    #2 check("drain.empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    tick();

    // Forwarding priority
    push(32'h10, enc_addu(5'd3, 5'd1, 5'd2));
    ex_wreg = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h11;
    mem_wreg = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'h22;
    rf_rdata1 = 32'hAAAA; rf_rdata2 = 32'hBBBB;
    #2;
    check("fwd.rdata1_ex",  out_rdata1, 32'h11);
    check("fwd.rdata2_mem", out_rdata2, 32'h22);
    check("fwd.raddr1",     32'(rf_raddr1), 32'd1);
    check("fwd.raddr2",     32'(rf_raddr2), 32'd2);
    check("fwd.waddr_rd",   32'(out_rf_waddr), 32'd3);
    mem_waddr = 5'd1;
    #1;
    check("fwd.ex_over_mem", out_rdata1, 32'h11);
    check("fwd.rf_fallback", out_rdata2, 32'hBBBB);
    ex_wreg = 1'b0;
    #1 check("fwd.mem_only", out_rdata1, 32'h22);
    mem_wreg = 1'b0; rf_rdata1 = '0; rf_rdata2 = '0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Load-use stall
    ex_wreg = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd5; out_ready = 1'b1;
    push(32'h20, enc_i(6'h09, 5'd5, 5'd6, 16'd1));
    #2;
    check("lu.out_valid", 32'(out_valid), 32'd0);
    check("lu.stallreq",  32'(stallreq), 32'd1);
    tick();
    #2 check("lu.held", 32'(out_valid), 32'd0);
    ex_is_load = 1'b0; ex_wreg = 1'b0;
    #1;
    check("lu.release_valid", 32'(out_valid), 32'd1);
    check("lu.release_stall", 32'(stallreq), 32'd0);
    check("lu.release_pc",    out_pc, 32'h20);
    tick();
    #2 check("lu.popped", 32'(out_valid), 32'd0);
    // lui does not read rs, so a matching rs field must not stall
    ex_wreg = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd5; out_ready = 1'b0;
    push(32'h24, enc_i(6'h0F, 5'd5, 5'd7, 16'h1234));
    #2;
    check("lui.no_stall", 32'(out_valid), 32'd1);
    check("lui.waddr",    32'(out_rf_waddr), 32'd7);
    out_ready = 1'b1;
    tick();
    ex_wreg = 1'b0; ex_is_load = 1'b0; ex_waddr = '0; out_ready = 1'b0;

    // Taken beq with three entries behind: only the delay slot survives
    rf_rdata1 = 32'd7; rf_rdata2 = 32'd7;
    push(32'h100, enc_i(6'h04, 5'd1, 5'd2, 16'd4));
    for (int i = 1; i < 4; i++) push(32'(32'h100 + i * 4), enc_i(6'h09, 5'd0, 5'd8, 16'(i)));
    out_ready = 1'b1;
    #2;
    check("beq.br_e",    32'(br_e), 32'd1);
    check("beq.br_addr", br_addr, 32'h114);
    tick();
    #2;
    check("beq.ds_pc",   out_pc, 32'h104);
    check("beq.ds_br_e", 32'(br_e), 32'd0);
    tick();
    #2 check("beq.rest_dropped", 32'(out_valid), 32'd0);

    // Not-taken beq, then taken bne with a negative offset
    out_ready = 1'b0; rf_rdata2 = 32'd9;
    push(32'h300, enc_i(6'h04, 5'd1, 5'd2, 16'd4));
    out_ready = 1'b1;
    #2;
    check("beq_nt.valid",   32'(out_valid), 32'd1);
    check("beq_nt.br_e",    32'(br_e), 32'd0);
    check("beq_nt.br_addr", br_addr, 32'd0);
    tick();
    out_ready = 1'b0;
    push(32'h310, enc_i(6'h05, 5'd1, 5'd2, 16'hFFFF));
    out_ready = 1'b1;
    #2;
    check("bne.br_e",    32'(br_e), 32'd1);
    check("bne.br_addr", br_addr, 32'h310);
    tick();
    rf_rdata1 = '0; rf_rdata2 = '0; out_ready = 1'b0;
    push(32'h314, 32'd0);   // delay slot for the bne
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // jal alone in queue: delay slot fetched later is kept
    push(32'h200, {6'h03, 26'h40});
    out_ready = 1'b1;
    #2;
    check("jal.br_e",    32'(br_e), 32'd1);
    check("jal.br_addr", br_addr, 32'h100);
    check("jal.waddr",   32'(out_rf_waddr), 32'd31);
    check("jal.we",      32'(out_rf_we), 32'd1);
    tick();
    #2 check("jal.empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    push(32'h204, enc_i(6'h09, 5'd0, 5'd9, 16'd1));
    #2;
    check("jal.ds_valid", 32'(out_valid), 32'd1);
    check("jal.ds_pc",    out_pc, 32'h204);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    // flush while waiting for the delay slot
    push(32'h200, {6'h03, 26'h40});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h204; in_inst = enc_i(6'h09, 5'd0, 5'd9, 16'd1);
    #2 check("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #2 check("flush.empty", 32'(out_valid), 32'd0);
    push(32'h400, enc_i(6'h0D, 5'd0, 5'd4, 16'h00FF));
    push(32'h404, enc_i(6'h0D, 5'd0, 5'd4, 16'h00FF));
    #2 check("post_flush.pc", out_pc, 32'h400);
    flush = 1'b1;
    #1 check("flush2.out_valid", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0;
    #2 check("flush2.empty", 32'(out_valid), 32'd0);

    // Reset in mid-operation
    for (int i = 0; i < 3; i++) push(32'(32'h500 + i * 4), enc_i(6'h09, 5'd0, 5'd1, 16'(i)));
    #2 check("midrst.pre_valid", 32'(out_valid), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready",  32'(in_ready), 32'd0);
    check("midrst.out_pc",    out_pc, 32'd0);
    tick();
    resetn = 1'b1;
    #2 check("midrst.in_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    #2;
    check("midrst.in_ready_after_edge", 32'(in_ready), 32'd1);
    check("midrst.emptied",             32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
